// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
// The core's decode/control stage imports the same package.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store data port: request and response valid/ready channels.
interface data_mem_responder_if #(
  parameter int ADDR_W = 32
) ();
  import data_mem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              req_we;
  size_e             req_size;
  logic              req_sign_extend;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;

  modport master (
    output req_valid, req_addr, req_wdata, req_we, req_size, req_sign_extend, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_we, req_size, req_sign_extend, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Combinational byte-lane steering: store mask/data placement, load alignment and
// extension, and the alignment check for the requested size.
module data_mem_responder_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  size_e       size_i,
  input  logic        sign_extend_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign lane_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    wmask_o    = 4'b0000;
    wword_o    = 32'h0;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        wmask_o = 4'b0001 << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_extend_i & lane_byte[7]}}, lane_byte};
      end
      SIZE_HALF: begin
        misalign_o = addr_lo_i[0];
        wmask_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{sign_extend_i & lane_half[15]}}, lane_half};
      end
      SIZE_WORD: begin
        misalign_o = |addr_lo_i;
        wmask_o    = 4'b1111;
        wword_o    = wdata_i;
        rdata_o    = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with a configurable wait-state delay in
// front of a word-wide internal RAM.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic [ADDR_W-1:0]     addr_q;
  logic [31:0]           wdata_q;
  logic                  we_q;
  size_e                 size_q;
  logic                  sext_q;

  logic [31:0]           mem [DEPTH_WORDS];

  logic                  accept;
  logic [IDX_W-1:0]      widx;
  logic                  out_of_range;
  logic [31:0]           rword;
  logic [3:0]            wmask;
  logic [31:0]           wword;
  logic [31:0]           load_data;
  logic                  misalign;
  logic                  access_err;
  logic                  mem_we;

  assign bus.req_ready = (state_q == ST_IDLE) && reset_n;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = error_q;
  assign accept        = bus.req_valid && bus.req_ready;

  // Word index beyond the array is an error, never a wrap-around.
  assign widx         = addr_q[IDX_W+1:2];
  assign out_of_range = {2'b00, addr_q[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS);
  assign rword        = mem[widx];
  assign access_err   = misalign || (size_q == SIZE_RSVD) || out_of_range;
  assign mem_we       = (state_q == ST_ACCESS) && we_q && !access_err && reset_n;

  data_mem_responder_lane_align u_lane_align (
    .addr_lo_i     (addr_q[1:0]),
    .size_i        (size_q),
    .sign_extend_i (sext_q),
    .wdata_i       (wdata_q),
    .rword_i       (rword),
    .wmask_o       (wmask),
    .wword_o       (wword),
    .rdata_o       (load_data),
    .misalign_o    (misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
          cnt_d   = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        error_d = access_err;
        rdata_d = (access_err || we_q) ? 32'h0 : load_data;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Capture registers are only consumed after an accept, so they carry no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      sext_q  <= bus.req_sign_extend;
    end
  end

  // NOTE: RAM contents are deliberately not reset; a reset loop would block RAM inference.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed vector tables for two builds (2 and 0 wait states),
// backpressure and mid-operation reset sequences, and randomized traffic against a byte-array model.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int DEPTH0 = 1024;
  localparam int DEPTH1 = 64;
  localparam int TMO    = 40;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  data_mem_responder_if #(.ADDR_W(32)) bif0 ();
  data_mem_responder_if #(.ADDR_W(32)) bif1 ();

  logic        sel;
  logic        drv_valid, drv_rsp_ready, drv_we, drv_sext;
  logic [31:0] drv_addr, drv_wdata;
  size_e       drv_size;

  assign bif0.req_valid       = drv_valid & ~sel;
  assign bif0.rsp_ready       = drv_rsp_ready & ~sel;
  assign bif0.req_addr        = drv_addr;
  assign bif0.req_wdata       = drv_wdata;
  assign bif0.req_we          = drv_we;
  assign bif0.req_size        = drv_size;
  assign bif0.req_sign_extend = drv_sext;
  assign bif1.req_valid       = drv_valid & sel;
  assign bif1.rsp_ready       = drv_rsp_ready & sel;
  assign bif1.req_addr        = drv_addr;
  assign bif1.req_wdata       = drv_wdata;
  assign bif1.req_we          = drv_we;
  assign bif1.req_size        = drv_size;
  assign bif1.req_sign_extend = drv_sext;

  logic        cur_req_ready, cur_rsp_valid, cur_rsp_error;
  logic [31:0] cur_rsp_rdata;
  assign cur_req_ready = sel ? bif1.req_ready : bif0.req_ready;
  assign cur_rsp_valid = sel ? bif1.rsp_valid : bif0.rsp_valid;
  assign cur_rsp_error = sel ? bif1.rsp_error : bif0.rsp_error;
  assign cur_rsp_rdata = sel ? bif1.rsp_rdata : bif0.rsp_rdata;

  data_mem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_STATES(2), .ADDR_W(32)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bif0)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH1), .WAIT_STATES(0), .ADDR_W(32)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bif1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model of dut0: byte-addressed memory, little-endian, rules applied directly.
  logic [7:0] ref_mem [4*DEPTH0];

  function automatic void model_access(input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic we, input size_e size, input logic sext,
                                       output logic [31:0] rdata, output logic err);
    int unsigned n;
    logic [31:0] v;
    n = (size == SIZE_BYTE) ? 1 : (size == SIZE_HALF) ? 2 : 4;
    err = (size == SIZE_RSVD) || (addr % n != 0) || (addr / 4 >= DEPTH0);
    rdata = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < int'(n); i++) ref_mem[addr + i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < int'(n); i++) v = v | ({24'h0, ref_mem[addr + i]} << (8 * i));
      if (sext && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      rdata = v;
    end
  endfunction

  task automatic transact(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                          input size_e size, input logic sext,
                          output logic [31:0] rdata, output logic err, output int lat);
    int guard = 0;
    while (!cur_req_ready && guard < TMO) begin
      @(posedge clock); #1;
      guard++;
    end
    check("req_ready_timeout", 32'(guard >= TMO), 32'h0);
    drv_addr  = addr;
    drv_wdata = wdata;
    drv_we    = we;
    drv_size  = size;
    drv_sext  = sext;
    drv_valid = 1'b1;
    @(posedge clock); #1;
    drv_valid = 1'b0;
    lat = 0;
    while (!cur_rsp_valid && lat < TMO) begin
      @(posedge clock); #1;
      lat++;
    end
    check("rsp_valid_timeout", 32'(lat >= TMO), 32'h0);
    rdata = cur_rsp_rdata;
    err   = cur_rsp_error;
    drv_rsp_ready = 1'b1;
    @(posedge clock); #1;
    drv_rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    size_e       size;
    logic        sext;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs0[$];
  vec_t vecs1[$];

  initial begin
    logic [31:0] rd, exp_rd, hold_rd;
    logic        er, exp_er, hold_er;
    int          lat, guard;

    sel = 1'b0;
    drv_valid = 1'b0; drv_rsp_ready = 1'b0; drv_we = 1'b0; drv_sext = 1'b0;
    drv_addr = 32'h0; drv_wdata = 32'h0; drv_size = SIZE_WORD;
    for (int i = 0; i < 4*DEPTH0; i++) ref_mem[i] = 8'h00;

    vecs0.push_back('{32'h10,  32'hDEADBEEF, 1'b1, SIZE_WORD, 1'b0, 32'h0,        1'b0});
    vecs0.push_back('{32'h10,  32'h0,        1'b0, SIZE_WORD, 1'b0, 32'hDEADBEEF, 1'b0});
    vecs0.push_back('{32'h13,  32'h00000080, 1'b1, SIZE_BYTE, 1'b0, 32'h0,        1'b0});
    vecs0.push_back('{32'h10,  32'h0,        1'b0, SIZE_WORD, 1'b0, 32'h80ADBEEF, 1'b0});
    vecs0.push_back('{32'h13,  32'h0,        1'b0, SIZE_BYTE, 1'b1, 32'hFFFFFF80, 1'b0});
    vecs0.push_back('{32'h13,  32'h0,        1'b0, SIZE_BYTE, 1'b0, 32'h00000080, 1'b0});
    vecs0.push_back('{32'h12,  32'hABCD8001, 1'b1, SIZE_HALF, 1'b0, 32'h0,        1'b0});
    vecs0.push_back('{32'h12,  32'h0,        1'b0, SIZE_HALF, 1'b1, 32'hFFFF8001, 1'b0});
    vecs0.push_back('{32'h11,  32'h0,        1'b0, SIZE_HALF, 1'b1, 32'h0,        1'b1});
    vecs0.push_back('{32'h10,  32'h0,        1'b0, SIZE_WORD, 1'b0, 32'h8001BEEF, 1'b0});
    vecs0.push_back('{32'h12,  32'h0,        1'b0, SIZE_HALF, 1'b0, 32'h00008001, 1'b0});
    vecs0.push_back('{32'h10,  32'h0,        1'b0, SIZE_BYTE, 1'b1, 32'hFFFFFFEF, 1'b0});
    vecs0.push_back('{32'h1000,32'h0,        1'b0, SIZE_WORD, 1'b0, 32'h0,        1'b1});
    vecs0.push_back('{32'h1000,32'h55555555, 1'b1, SIZE_WORD, 1'b0, 32'h0,        1'b1});
    vecs0.push_back('{32'h10,  32'hFFFFFFFF, 1'b1, SIZE_RSVD, 1'b0, 32'h0,        1'b1});
    vecs0.push_back('{32'h12,  32'h11111111, 1'b1, SIZE_WORD, 1'b0, 32'h0,        1'b1});
    vecs0.push_back('{32'h10,  32'h0,        1'b0, SIZE_WORD, 1'b0, 32'h8001BEEF, 1'b0});
    vecs0.push_back('{32'hFFC, 32'hCAFEF00D, 1'b1, SIZE_WORD, 1'b0, 32'h0,        1'b0});
    vecs0.push_back('{32'hFFC, 32'h0,        1'b0, SIZE_WORD, 1'b1, 32'hCAFEF00D, 1'b0});

    vecs1.push_back('{32'h0,   32'h11223344, 1'b1, SIZE_WORD, 1'b0, 32'h0,        1'b0});
    vecs1.push_back('{32'h0,   32'h0,        1'b0, SIZE_WORD, 1'b0, 32'h11223344, 1'b0});
    vecs1.push_back('{32'h100, 32'h0,        1'b0, SIZE_WORD, 1'b0, 32'h0,        1'b1});
    vecs1.push_back('{32'h100, 32'h99999999, 1'b1, SIZE_WORD, 1'b0, 32'h0,        1'b1});
    vecs1.push_back('{32'h0,   32'h0,        1'b0, SIZE_RSVD, 1'b0, 32'h0,        1'b1});
    vecs1.push_back('{32'hFC,  32'hA5A5A5A5, 1'b1, SIZE_WORD, 1'b0, 32'h0,        1'b0});
    vecs1.push_back('{32'hFC,  32'h0,        1'b0, SIZE_WORD, 1'b0, 32'hA5A5A5A5, 1'b0});
    vecs1.push_back('{32'hFF,  32'h0,        1'b0, SIZE_BYTE, 1'b1, 32'hFFFFFFA5, 1'b0});
    vecs1.push_back('{32'hFE,  32'h0,        1'b0, SIZE_HALF, 1'b0, 32'h0000A5A5, 1'b0});
    vecs1.push_back('{32'h0,   32'h0,        1'b0, SIZE_WORD, 1'b0, 32'h11223344, 1'b0});

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_req_ready0", 32'(bif0.req_ready), 32'h0);
    check("reset_rsp_valid0", 32'(bif0.rsp_valid), 32'h0);
    check("reset_rsp_rdata0", bif0.rsp_rdata, 32'h0);
    check("reset_rsp_error0", 32'(bif0.rsp_error), 32'h0);
    check("reset_rsp_valid1", 32'(bif1.rsp_valid), 32'h0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_reset_req_ready0", 32'(bif0.req_ready), 32'h1);
    check("post_reset_req_ready1", 32'(bif1.req_ready), 32'h1);

    // Directed tables: 2 wait states, then the 0-wait build
    foreach (vecs0[i]) begin
      transact(vecs0[i].addr, vecs0[i].wdata, vecs0[i].we, vecs0[i].size, vecs0[i].sext, rd, er, lat);
      check($sformatf("v0[%0d] rdata", i), rd, vecs0[i].exp_rdata);
      check($sformatf("v0[%0d] error", i), 32'(er), 32'(vecs0[i].exp_err));
      check($sformatf("v0[%0d] latency", i), lat, 32'd3);
    end
    sel = 1'b1;
    foreach (vecs1[i]) begin
      transact(vecs1[i].addr, vecs1[i].wdata, vecs1[i].we, vecs1[i].size, vecs1[i].sext, rd, er, lat);
      check($sformatf("v1[%0d] rdata", i), rd, vecs1[i].exp_rdata);
      check($sformatf("v1[%0d] error", i), 32'(er), 32'(vecs1[i].exp_err));
      check($sformatf("v1[%0d] latency", i), lat, 32'd1);
    end
    sel = 1'b0;

    // Backpressure: response held 5 cycles, a second request waits for handshake+1
    drv_addr = 32'h10; drv_wdata = 32'h0; drv_we = 1'b0; drv_size = SIZE_WORD; drv_sext = 1'b0;
    drv_valid = 1'b1;
    @(posedge clock); #1;
    drv_addr = 32'h13; drv_size = SIZE_BYTE;
    guard = 0;
    while (!cur_rsp_valid && guard < TMO) begin
      @(posedge clock); #1;
      guard++;
    end
    check("bp_rsp_timeout", 32'(guard >= TMO), 32'h0);
    hold_rd = cur_rsp_rdata;
    hold_er = cur_rsp_error;
    check("bp_first_rdata", hold_rd, 32'h8001BEEF);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      check($sformatf("bp_hold%0d rsp_valid", c), 32'(cur_rsp_valid), 32'h1);
      check($sformatf("bp_hold%0d rdata", c), cur_rsp_rdata, 32'h8001BEEF);
      check($sformatf("bp_hold%0d error", c), 32'(cur_rsp_error), 32'(hold_er));
      check($sformatf("bp_hold%0d req_ready", c), 32'(cur_req_ready), 32'h0);
    end
    drv_rsp_ready = 1'b1;
    @(posedge clock); #1;
    drv_rsp_ready = 1'b0;
    check("bp_after_hs rsp_valid", 32'(cur_rsp_valid), 32'h0);
    check("bp_after_hs req_ready", 32'(cur_req_ready), 32'h1);
    @(posedge clock); #1;
    drv_valid = 1'b0;
    check("bp_second_accepted", 32'(cur_req_ready), 32'h0);
    lat = 0;
    while (!cur_rsp_valid && lat < TMO) begin
      @(posedge clock); #1;
      lat++;
    end
    check("bp_second_latency", lat, 32'd3);
    check("bp_second_rdata", cur_rsp_rdata, 32'h00000080);
    drv_rsp_ready = 1'b1;
    @(posedge clock); #1;
    drv_rsp_ready = 1'b0;

    // Reset during WAIT abandons the store
    transact(32'h20, 32'h0, 1'b1, SIZE_WORD, 1'b0, rd, er, lat);
    drv_addr = 32'h20; drv_wdata = 32'h12345678; drv_we = 1'b1; drv_size = SIZE_WORD;
    drv_valid = 1'b1;
    @(posedge clock); #1;
    drv_valid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("midreset rsp_valid", 32'(cur_rsp_valid), 32'h0);
    check("midreset req_ready", 32'(cur_req_ready), 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("midreset_release req_ready", 32'(cur_req_ready), 32'h1);
    check("midreset_release rsp_valid", 32'(cur_rsp_valid), 32'h0);
    transact(32'h20, 32'h0, 1'b0, SIZE_WORD, 1'b0, rd, er, lat);
    check("midreset_store_dropped", rd, 32'h0);
    check("midreset_load_error", 32'(er), 32'h0);

    // Randomized traffic against the model over an initialised window
    for (int w = 0; w < 64; w++) begin
      model_access(32'h100 + 32'(4*w), 32'h0, 1'b1, SIZE_WORD, 1'b0, exp_rd, exp_er);
      transact(32'h100 + 32'(4*w), 32'h0, 1'b1, SIZE_WORD, 1'b0, rd, er, lat);
    end
    for (int t = 0; t < 250; t++) begin
      logic [31:0] a, wd;
      logic        we, sx;
      size_e       sz;
      a  = ($urandom_range(0, 15) == 0) ? (32'h1000 + 32'($urandom_range(0, 4095)))
                                         : (32'h100 + 32'($urandom_range(0, 255)));
      wd = $urandom;
      we = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      sz = size_e'($urandom_range(0, 3));
      model_access(a, wd, we, sz, sx, exp_rd, exp_er);
      transact(a, wd, we, sz, sx, rd, er, lat);
      check($sformatf("rnd%0d a=%h we=%0d sz=%0d rdata", t, a, we, sz), rd, exp_rd);
      check($sformatf("rnd%0d a=%h error", t, a), 32'(er), 32'(exp_er));
      check($sformatf("rnd%0d latency", t), lat, 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
